la_pgctrl: RTL and testbench

LA_PGCTRL -- requirements
Module: la_pgctrl

---
 rtl/la_pgctrl.sv | 135 +++++++++++++
 tb/tb_la_pgctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/la_pgctrl.sv
// Power-gating sequencer for a header-switched domain: staggered segment wake-up,
// supply settle, retention restore, and the isolate/save/gate power-down sequence.
module la_pgctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned STEP   = 8,
    parameter int unsigned SETTLE = 16,
    parameter              PROP   = "DEFAULT"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwr_req,
    output logic [N-1:0] sleep,
    output logic         iso,
    output logic         ret,
    output logic         ready,
    output logic         busy
);

    localparam int unsigned MAXC = (STEP > SETTLE) ? STEP : SETTLE;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAKE,
        S_SETTLE,
        S_RESTORE,
        S_ON,
        S_ISO,
        S_SAVE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sleep_d;
    logic           iso_d, ret_d, ready_d, busy_d;

    // Implementation-property tag only; selects no logic.
    if (PROP != "DEFAULT") begin : g_prop_custom
    end

    // Next-state and next-output logic; the sleep vector doubles as the segment
    // index since segments always wake lowest-first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sleep_d = sleep;
        iso_d   = iso;
        ret_d   = ret;
        ready_d = ready;
        busy_d  = busy;
        case (state_q)
            S_OFF: begin
                sleep_d = {N{1'b1}};
                iso_d   = 1'b1;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                if (pwr_req) begin
                    sleep_d = {N{1'b1}} << 1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (N == 1) ? S_SETTLE : S_WAKE;
                end
            end
            S_WAKE: begin
                if (cnt_q == CW'(STEP - 1)) begin
                    cnt_d   = '0;
                    sleep_d = sleep << 1;
                    if (!sleep_d[N-1]) begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    ret_d   = 1'b0;
                    iso_d   = 1'b1;
                    state_d = S_RESTORE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESTORE: begin
                iso_d   = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_ON;
            end
            S_ON: begin
                if (!pwr_req) begin
                    iso_d   = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_ISO;
                end
            end
            S_ISO: begin
                ret_d   = 1'b1;
                state_d = S_SAVE;
            end
            S_SAVE: begin
                sleep_d = {N{1'b1}};
                busy_d  = 1'b0;
                state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            sleep   <= {N{1'b1}};
            iso     <= 1'b1;
            ret     <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sleep   <= sleep_d;
            iso     <= iso_d;
            ret     <= ret_d;
            ready   <= ready_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_la_pgctrl.sv
// Bench for la_pgctrl: directed timing tables, corner sequences, and a random run
// checked against a time-since-request reference model, on default and minimal instances.
module tb_la_pgctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       r0, p0, r1, p1;
    logic [3:0] sleep0;
    logic       iso0, ret0, ready0, busy0;
    logic [0:0] sleep1;
    logic       iso1, ret1, ready1, busy1;

    la_pgctrl u_dut0 (
        .clk(clk), .reset(r0), .pwr_req(p0),
        .sleep(sleep0), .iso(iso0), .ret(ret0), .ready(ready0), .busy(busy0)
    );

    la_pgctrl #(.N(1), .STEP(1), .SETTLE(1), .PROP("MIN")) u_dut1 (
        .clk(clk), .reset(r1), .pwr_req(p1),
        .sleep(sleep1), .iso(iso1), .ret(ret1), .ready(ready1), .busy(busy1)
    );

    int total = 0;
    int passed = 0;
    int cyc_no = 0;
    bit inv_en = 1'b0;

    // Reference model: mode 0=off 1=powering up 2=on 3=powering down; e counts cycles in the sequence.
    typedef struct {
        int mode;
        int e;
        bit ret;
    } mdl_t;

    mdl_t m0, m1;

    typedef struct {
        int       cyc;
        logic [3:0] sleep;
        logic     iso;
        logic     ret;
        logic     ready;
        logic     busy;
    } row_t;

    row_t up_tab[10];
    row_t dn_tab[3];

    function automatic mdl_t mstep(mdl_t m, bit r, bit p, int n, int st, int se);
        int   up_len = (n - 1) * st + se + 1;
        mdl_t x = m;
        if (r) begin
            x.mode = 0; x.e = 0; x.ret = 1'b0;
        end else begin
            case (m.mode)
                0: if (p) begin x.mode = 1; x.e = 1; end
                1: begin
                    x.e = m.e + 1;
                    if (x.e == up_len) x.ret = 1'b0;
                    if (x.e > up_len) begin x.mode = 2; x.e = 0; end
                end
                2: if (!p) begin x.mode = 3; x.e = 1; end
                3: begin
                    x.e = m.e + 1;
                    if (x.e == 2) x.ret = 1'b1;
                    if (x.e == 3) begin x.mode = 0; x.e = 0; end
                end
                default: ;
            endcase
        end
        return x;
    endfunction

    function automatic logic [11:0] mexp(mdl_t m, int n, int st);
        int         all = (1 << n) - 1;
        int         c = 0;
        logic [7:0] s = 8'd0;
        logic       i = 1'b1, rd = 1'b0, b = 1'b0;
        case (m.mode)
            0: begin s = 8'(all); i = 1'b1; rd = 1'b0; b = 1'b0; end
            1: begin
                c = (m.e - 1) / st + 1;
                if (c > n) c = n;
                s = 8'(all & ~((1 << c) - 1));
                i = 1'b1; rd = 1'b0; b = 1'b1;
            end
            2: begin s = 8'd0; i = 1'b0; rd = 1'b1; b = 1'b0; end
            default: begin s = 8'd0; i = 1'b1; rd = 1'b0; b = 1'b1; end
        endcase
        return {s, i, m.ret, rd, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: DUTs sample current inputs, model follows, both instances compared.
    task automatic tick();
        bit r0s = r0, p0s = p0, r1s = r1, p1s = p1;
        @(posedge clk);
        #1;
        cyc_no++;
        m0 = mstep(m0, r0s, p0s, 4, 8, 16);
        m1 = mstep(m1, r1s, p1s, 1, 1, 1);
        chk($sformatf("model0 cyc%0d", cyc_no),
            32'({4'b0, sleep0, iso0, ret0, ready0, busy0}), 32'(mexp(m0, 4, 8)));
        chk($sformatf("model1 cyc%0d", cyc_no),
            32'({7'b0, sleep1, iso1, ret1, ready1, busy1}), 32'(mexp(m1, 1, 1)));
    endtask

    // Structural invariants on both instances.
    always @(negedge clk) begin
        if (inv_en) begin
            assert (iso0 || sleep0 == 4'b0) begin total++; passed++; end
            else begin total++; $display("FAIL inv_iso0 sleep=%b iso=%b", sleep0, iso0); end
            assert (!ready0 || (sleep0 == 4'b0 && !iso0 && !ret0)) begin total++; passed++; end
            else begin total++; $display("FAIL inv_ready0 sleep=%b iso=%b ret=%b", sleep0, iso0, ret0); end
            assert (iso1 || sleep1 == 1'b0) begin total++; passed++; end
            else begin total++; $display("FAIL inv_iso1 sleep=%b iso=%b", sleep1, iso1); end
            assert (!ready1 || (sleep1 == 1'b0 && !iso1 && !ret1)) begin total++; passed++; end
            else begin total++; $display("FAIL inv_ready1 sleep=%b iso=%b ret=%b", sleep1, iso1, ret1); end
        end
    end

    initial begin
        int n;
        up_tab[0] = '{1,  4'b1110, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[1] = '{8,  4'b1110, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[2] = '{9,  4'b1100, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[3] = '{16, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[4] = '{17, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[5] = '{24, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[6] = '{25, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[7] = '{40, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[8] = '{41, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
        up_tab[9] = '{42, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        dn_tab[0] = '{1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
        dn_tab[1] = '{2, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
        dn_tab[2] = '{3, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};

        m0 = '{0, 0, 1'b0};
        m1 = '{0, 0, 1'b0};
        r0 = 1'b1; p0 = 1'b0; r1 = 1'b1; p1 = 1'b0;
        tick();
        inv_en = 1'b1;
        tick();
        r0 = 1'b0; r1 = 1'b0;

        // Idle with no request.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle %0d", i), 32'({sleep0, iso0, ret0, ready0, busy0}),
                32'({4'b1111, 1'b1, 1'b0, 1'b0, 1'b0}));
        end

        // Power-up timing table.
        p0 = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            tick();
            for (int k = 0; k < 10; k++) begin
                if (up_tab[k].cyc == c)
                    chk($sformatf("up c%0d", c), 32'({sleep0, iso0, ret0, ready0, busy0}),
                        32'({up_tab[k].sleep, up_tab[k].iso, up_tab[k].ret, up_tab[k].ready, up_tab[k].busy}));
            end
        end
        repeat (3) tick();

        // Power-down timing table.
        p0 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (dn_tab[k].cyc == c)
                    chk($sformatf("down c%0d", c), 32'({sleep0, iso0, ret0, ready0, busy0}),
                        32'({dn_tab[k].sleep, dn_tab[k].iso, dn_tab[k].ret, dn_tab[k].ready, dn_tab[k].busy}));
            end
        end
        repeat (3) tick();

        // Request dropped mid-wake: power-up completes, then powers down.
        p0 = 1'b1;
        repeat (5) tick();
        chk("ret_held_in_wake", 32'(ret0), 32'd1);
        p0 = 1'b0;
        n = 0;
        while (!ready0 && n < 60) begin
            tick();
            n++;
        end
        chk("drop_ready_reached", 32'(ready0), 32'd1);
        tick();
        chk("drop_iso", 32'({iso0, ready0, busy0}), 32'(3'b101));
        tick();
        tick();
        chk("drop_off", 32'({sleep0, busy0}), 32'(5'b11110));

        // Reset during settle, then restart from segment 0.
        p0 = 1'b1;
        repeat (30) tick();
        chk("settle_pre_reset", 32'({sleep0, busy0}), 32'(5'b00001));
        r0 = 1'b1;
        tick();
        chk("settle_reset", 32'({sleep0, iso0, ret0, ready0, busy0}),
            32'({4'b1111, 1'b1, 1'b0, 1'b0, 1'b0}));
        r0 = 1'b0;
        tick();
        chk("restart", 32'({sleep0, busy0}), 32'(5'b11101));
        repeat (45) tick();

        // Minimal instance: single segment, unit step and settle.
        p1 = 1'b1;
        tick();
        chk("n1 t+1", 32'({sleep1, ready1, busy1}), 32'(3'b001));
        tick();
        chk("n1 t+2", 32'({ret1, ready1, iso1}), 32'(3'b001));
        tick();
        chk("n1 t+3", 32'({ready1, iso1, busy1}), 32'(3'b100));

        // Random requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 20 == 0) p0 = ~p0;
            if ($urandom % 7 == 0) p1 = ~p1;
            r0 = ($urandom % 250 == 0);
            r1 = ($urandom % 250 == 0);
            tick();
        end
        r0 = 1'b0; r1 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
